// File: rtl/uart_tx_ctrl_if.sv
// Bus between the system controller and the UART transmit controller.
// Handshake: DATA_VALID is a request, and BUSY acts as its inverse ready.
// A request is consumed at any rising CLK edge where the controller is
// idle (BUSY low). While BUSY is high, DATA_VALID and its payload are
// ignored. The payload is P_DATA, PAR_EN and PAR_TYP.
interface uart_tx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [1:0]            MUX_SEL;
    logic                  SER_DATA;
    logic                  PAR_BIT;
    logic                  BUSY;
    logic [2:0]            dbg_state;

    // System controller side.
    modport master (
        output P_DATA,
        output DATA_VALID,
        output PAR_EN,
        output PAR_TYP,
        input  MUX_SEL,
        input  SER_DATA,
        input  PAR_BIT,
        input  BUSY,
        input  dbg_state
    );

    // Transmit controller side.
    modport slave (
        input  P_DATA,
        input  DATA_VALID,
        input  PAR_EN,
        input  PAR_TYP,
        output MUX_SEL,
        output SER_DATA,
        output PAR_BIT,
        output BUSY,
        output dbg_state
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: sequences start, data (LSB first), optional
// parity and stop bits, one bit per CLK. It drives the TX mux select,
// the serial data bit and the parity bit. Every output comes straight
// from a flop, and each flop is loaded from the decoded next state.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic           CLK,
    input  logic           RST,
    uart_tx_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    localparam logic [1:0] SEL_START  = 2'b00;
    localparam logic [1:0] SEL_DATA   = 2'b01;
    localparam logic [1:0] SEL_PARITY = 2'b10;
    localparam logic [1:0] SEL_STOP   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic [1:0]            mux_sel_q, mux_sel_d;
    logic                  ser_data_q, ser_data_d;
    logic                  busy_q, busy_d;

    // Next-state logic. It also computes the datapath and the output values for the next cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        ser_data_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.DATA_VALID) begin
                    // Latch the whole request. Parity is fixed here for the rest of the frame.
                    state_d   = S_START;
                    shift_d   = bus.P_DATA;
                    par_en_d  = bus.PAR_EN;
                    par_bit_d = (^bus.P_DATA) ^ bus.PAR_TYP;
                    cnt_d     = '0;
                end
            end
            S_START: begin
                // Preload bit 0 so that it appears in the first data cycle.
                state_d    = S_DATA;
                cnt_d      = '0;
                ser_data_d = shift_q[0];
            end
            S_DATA: begin
                if (cnt_q == LAST_BIT) begin
                    state_d = par_en_q ? S_PARITY : S_STOP;
                end else begin
                    cnt_d      = cnt_q + 1'b1;
                    shift_d    = shift_q >> 1;
                    ser_data_d = shift_q[1];
                end
            end
            S_PARITY: begin
                state_d = S_STOP;
            end
            S_STOP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        case (state_d)
            S_START:  mux_sel_d = SEL_START;
            S_DATA:   mux_sel_d = SEL_DATA;
            S_PARITY: mux_sel_d = SEL_PARITY;
            default:  mux_sel_d = SEL_STOP;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State, datapath and output registers. A reset here aborts any frame that is in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            mux_sel_q  <= SEL_STOP;
            ser_data_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            mux_sel_q  <= mux_sel_d;
            ser_data_q <= ser_data_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.MUX_SEL   = mux_sel_q;
    assign bus.SER_DATA  = ser_data_q;
    assign bus.PAR_BIT   = par_bit_q;
    assign bus.BUSY      = busy_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl. It compares every line cycle against frames
// predicted from the request stream.
module tb_uart_tx_ctrl;
    localparam int W = 8;

    logic CLK = 1'b0;
    logic RST;
    int   tests = 0;
    int   fails = 0;

    // Each entry is packed as {mux_sel[1:0], busy, par_bit, check_ser, ser}.
    logic [5:0] exp_q[$];
    logic       cur_par = 1'b0;
    int         edge_n  = 0;
    int         free_at = 0;

    uart_tx_ctrl_if #(.DATA_WIDTH(W)) bus();

    uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    // Clock.
    always #5 CLK = ~CLK;

    // Reference model: given an accepted byte, list the expected line cycles.
    task automatic push_frame(input logic [W-1:0] d, input logic pe, input logic pt);
        logic par;
        int   len;
        par = logic'(($countones(d) % 2) == 1) ^ pt;
        cur_par = par;
        exp_q.push_back({2'b00, 1'b1, par, 1'b0, 1'b0});
        for (int i = 0; i < W; i++)
            exp_q.push_back({2'b01, 1'b1, par, 1'b1, d[i]});
        if (pe)
            exp_q.push_back({2'b10, 1'b1, par, 1'b0, 1'b0});
        exp_q.push_back({2'b11, 1'b1, par, 1'b0, 1'b0});
        len = W + 2 + (pe ? 1 : 0);
        free_at = edge_n + len + 1;
    endtask

    // Driver: hold the inputs across one rising edge, then update the model.
    task automatic drive_cycle(input logic rst_v, input logic dv, input logic [W-1:0] d,
                               input logic pe, input logic pt);
        RST            = rst_v;
        bus.DATA_VALID = dv;
        bus.P_DATA     = d;
        bus.PAR_EN     = pe;
        bus.PAR_TYP    = pt;
        @(posedge CLK);
        edge_n++;
        if (rst_v) begin
            exp_q.delete();
            cur_par = 1'b0;
            free_at = edge_n + 1;
        end else if (dv && edge_n >= free_at) begin
            push_frame(d, pe, pt);
        end
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Monitor and scoreboard: check the line on every falling edge.
    initial begin
        logic [5:0] e;
        logic [5:0] got;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {bus.MUX_SEL, bus.BUSY, bus.PAR_BIT, e[1], e[1] ? bus.SER_DATA : 1'b0};
                tests++;
                if (got !== e) begin
                    fails++;
                    $display("FAIL frame_cycle t=%0t: got mux=%b busy=%b par=%b ser=%b, want mux=%b busy=%b par=%b ser=%b",
                             $time, got[5:4], got[3], got[2], got[0], e[5:4], e[3], e[2], e[0]);
                end
            end else begin
                tests++;
                if (bus.MUX_SEL !== 2'b11 || bus.BUSY !== 1'b0 || bus.PAR_BIT !== cur_par) begin
                    fails++;
                    $display("FAIL idle_line t=%0t: got mux=%b busy=%b par=%b, want mux=11 busy=0 par=%b",
                             $time, bus.MUX_SEL, bus.BUSY, bus.PAR_BIT, cur_par);
                end
            end
        end
    end

    // Stimulus.
    initial begin
        // Reset is held for two cycles while a request is pending.
        drive_cycle(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
        @(negedge CLK);
        tests++;
        if (bus.SER_DATA !== 1'b0) begin
            fails++;
            $display("FAIL reset_ser: got %b want 0", bus.SER_DATA);
        end
        idle_cycles(2);

        // A5 without parity, then with even parity.
        drive_cycle(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
        idle_cycles(13);
        drive_cycle(1'b0, 1'b1, 8'hA5, 1'b1, 1'b0);
        idle_cycles(14);

        // Odd parity on 01 and on 03.
        drive_cycle(1'b0, 1'b1, 8'h01, 1'b1, 1'b1);
        idle_cycles(14);
        drive_cycle(1'b0, 1'b1, 8'h03, 1'b1, 1'b1);
        idle_cycles(14);

        // Pulse a request in mid-frame; it must be ignored.
        drive_cycle(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
        idle_cycles(3);
        drive_cycle(1'b0, 1'b1, 8'hFF, 1'b1, 1'b1);
        idle_cycles(12);

        // Hold the request for two back-to-back frames.
        for (int i = 0; i < 2 * (W + 3); i++) drive_cycle(1'b0, 1'b1, 8'h5C, 1'b0, 1'b0);
        idle_cycles(12);

        // Reset during data bit 3, then release with no request.
        drive_cycle(1'b0, 1'b1, 8'hC3, 1'b1, 1'b0);
        idle_cycles(4);
        drive_cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        idle_cycles(6);

        // Random traffic with rare resets.
        for (int i = 0; i < 500; i++) begin
            logic r, v, pe, pt;
            logic [W-1:0] d;
            r  = ($urandom_range(0, 149) == 0);
            v  = ($urandom_range(0, 2) == 0);
            pe = $urandom_range(0, 1) != 0;
            pt = $urandom_range(0, 1) != 0;
            d  = W'($urandom);
            drive_cycle(r, v, d, pe, pt);
        end
        idle_cycles(16);

        @(negedge CLK);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending cycles, want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Control and datapath stage of the UART transmitter, sitting directly upstream of the TX output mux.
- Accepts a parallel byte with a valid strobe, then sequences the start/data/parity/stop frame one bit per CLK (CLK is the TX bit clock).
- Drives the mux select, the serialised data bit and the computed parity bit, plus a BUSY flag back to the system controller.

Parameters:
- DATA_WIDTH, 8, width of P_DATA and number of data bits per frame (valid range 5..9).

Ports:
- CLK  input  1  TX bit clock; all state changes on rising edge.
- RST  input  1  synchronous, active-high reset.
- P_DATA  input  DATA_WIDTH  parallel data to transmit; sampled only on accept.
- DATA_VALID  input  1  request to send P_DATA.
- PAR_EN  input  1  1 = insert parity bit; sampled on accept.
- PAR_TYP  input  1  0 = even, 1 = odd parity; sampled on accept.
- MUX_SEL  output  2  frame-bit select to TX mux: 00 start, 01 data, 10 parity, 11 stop/idle.
- SER_DATA  output  1  current data bit, LSB first.
- PAR_BIT  output  1  parity of the latched word.
- BUSY  output  1  high while a frame is on the line.

Behaviour:
- One clock, CLK. RST is synchronous and active-high.
- Reset takes effect at the next CLK edge while RST=1:
  - state=IDLE, MUX_SEL=2'b11, SER_DATA=0, PAR_BIT=0, BUSY=0.
  - Bit counter and data shift register are cleared.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - MUX_SEL=11 (line high), BUSY=0.
  - DATA_VALID=1 at an edge is an accept: latch P_DATA, PAR_EN and PAR_TYP, compute PAR_BIT, go to START.
- START:
  - One cycle, MUX_SEL=00, BUSY=1.
  - SER_DATA is preloaded with P_DATA[0] for the next state.
  - Go to DATA, counter=0.
- DATA:
  - DATA_WIDTH cycles, MUX_SEL=01, BUSY=1, SER_DATA=latched bit[counter], LSB first.
  - After bit DATA_WIDTH-1: go to PARITY if the latched PAR_EN=1, else go to STOP.
- PARITY:
  - One cycle, MUX_SEL=10, BUSY=1.
- STOP:
  - One cycle, MUX_SEL=11, BUSY=1.
  - Then go to IDLE; BUSY drops in the first IDLE cycle.
- Parity:
  - Even: PAR_BIT = XOR-reduce of the latched word.
  - Odd: PAR_BIT = inverted XOR-reduce of the latched word.
  - Registered at accept; held stable until the next accept.
- Latency: accept edge to first start-bit cycle = 1 CLK.
- Frame length: 2+DATA_WIDTH cycles, or 3+DATA_WIDTH with parity.
- DATA_VALID, P_DATA, PAR_EN and PAR_TYP are ignored while BUSY=1. Changes mid-frame do not affect the frame in flight.
- Minimum one IDLE cycle between frames: a DATA_VALID held continuously produces back-to-back frames separated by exactly one IDLE cycle.
- RST asserted mid-frame aborts the frame. Outputs take reset values at that edge, leaving the line high via MUX_SEL=11.
- Counter width is ceil(log2(DATA_WIDTH)). The counter never wraps within a frame.

Test Plan:
- Reset: RST=1 for 2 cycles with DATA_VALID=1 -> MUX_SEL=11, BUSY=0, SER_DATA=0, PAR_BIT=0; no frame starts until RST=0.
- No parity: P_DATA=8'hA5, PAR_EN=0, 1-cycle DATA_VALID -> MUX_SEL sequence 00, 01×8, 11, then idle 11. SER_DATA during data = 1,0,1,0,0,1,0,1. BUSY high for exactly 10 cycles.
- Even parity: P_DATA=8'hA5, PAR_EN=1, PAR_TYP=0 -> 11-cycle frame with MUX_SEL=10 in cycle 10, PAR_BIT=0.
- Odd parity: P_DATA=8'h01, PAR_TYP=1 -> PAR_BIT=0. P_DATA=8'h03, PAR_TYP=1 -> PAR_BIT=1.
- Ignore while busy: P_DATA changed to 8'hFF and DATA_VALID pulsed mid-frame -> frame still carries 8'hA5 and no extra frame follows. Then holding DATA_VALID=1 -> next frame starts after exactly one IDLE cycle.
- Mid-frame reset: RST=1 during data bit 3 -> next cycle MUX_SEL=11, BUSY=0. After release with DATA_VALID=0, output stays idle.
